dvb_derandomizer: RTL and testbench
===================================

DVB_DERANDOMIZER -- requirements
Module: dvb_derandomizer

Interface
REQ-001 SHALL have parameter MISS_LIMIT, default 3, meaning consecutive bad group-start sync bytes that force loss of lock.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port CE, input, 1, one-clock strobe qualifying each input byte (RS decoder CEO).
REQ-005 SHALL have port input_byte, input, 8, decoded byte (RS decoder Out_byte).
REQ-006 SHALL have port Valid_in, input, 1, block-valid flag (RS decoder Valid_out); sampled only when CE=1.
REQ-007 SHALL have port Out_byte, output, 8, derandomized transport-stream byte.
REQ-008 SHALL have port CEO, output, 1, one-clock strobe per accepted input byte.
REQ-009 SHALL have port Valid_out, output, 1, high with CEO when Out_byte is a locked, derandomized byte.
REQ-010 SHALL have port Sop, output, 1, high with CEO on byte 0 of each 188-byte packet while locked.

Function
REQ-011 SHALL accept a byte only on a clock with CE=1 and Valid_in=1; CE=0 clocks change no state and hold all outputs except CEO.
REQ-012 SHALL register outputs: CEO=1 exactly one clock after each accepted byte, 0 otherwise; latency 1 clock; Out_byte/Valid_out/Sop held between strobes.
REQ-013 SHALL keep byte counter 0..187, incremented per accepted byte, wrapping 187->0, and packet counter 0..7, incremented on each byte-counter wrap, wrapping 7->0.
REQ-014 SHALL implement FSM states HUNT and LOCKED; reset enters HUNT.
REQ-015 HUNT: byte counter forced to 0 on each accepted byte that is not 0xB8; an accepted 0xB8 -> LOCKED, byte counter 1, packet counter 0, PRBS seeded; outputs Valid_out=0 for all other HUNT bytes.
REQ-016 SHALL use PRBS 1+x^14+x^15, register bits 1..15, seed 100101010000000 (bit1..bit15); per step out=bit14 XOR bit15, shift toward bit15, bit1<=out.
REQ-017 SHALL advance PRBS 8 steps per byte (8 steps in one clock), first output bit applied to byte MSB.
REQ-018 LOCKED, packet 0 byte 0: PRBS reseeded (no advance); Out_byte=0x47 if input is 0xB8.
REQ-019 LOCKED, packets 1..7 byte 0: Out_byte=input_byte unchanged; PRBS advances 8 steps (output discarded).
REQ-020 LOCKED, bytes 1..187: Out_byte=input_byte XOR PRBS byte; PRBS advances 8 steps; PRBS period per 8-packet group = 1503 bytes.
REQ-021 LOCKED: Valid_out=1 on every output byte, including the locking 0xB8 (output 0x47, Sop=1).
REQ-022 Packet 0 byte 0 not equal 0xB8: miss counter +1, byte still output as received with Valid_out=1, PRBS reseeded; a correct 0xB8 clears miss counter.
REQ-023 Miss counter reaching MISS_LIMIT -> HUNT on that byte, Valid_out=0 for it.
REQ-024 CE=1 with Valid_in=0 while byte counter != 0 (block truncated): -> HUNT, counters and miss counter cleared, CEO=1, Valid_out=0; at byte counter 0 it is ignored and lock kept.

Reset
REQ-025 On reset=1 at a clock edge: state HUNT, counters 0, PRBS seed, Out_byte=0x00, CEO=0, Valid_out=0, Sop=0; reset dominates a simultaneous CE.
REQ-026 Reset mid-packet SHALL discard the partial packet; next lock only via a new 0xB8.

Verification
REQ-027 Bytes 0x47,0x12 then 0xB8,0x00 -> first two Valid_out=0; then Out_byte 0x47 Sop=1 Valid_out=1, then 0x03 (first PRBS byte XOR 0x00).
REQ-028 Full 8-packet group scrambled by reference PRBS from an all-zero-payload stream -> 1504 outputs, all payload 0x00, eight byte-0 outputs 0x47, Sop=1 on each.
REQ-029 Three consecutive groups with group-start byte 0x47 instead of 0xB8 (MISS_LIMIT=3) -> first two still Valid_out=1, third Valid_out=0, state HUNT, subsequent bytes Valid_out=0 until 0xB8.
REQ-030 Valid_in=0 with CE=1 at byte counter 100 -> CEO=1, Valid_out=0, unlock; at byte counter 0 -> lock retained, next 0xB8 output 0x47.
REQ-031 reset=1 asserted at byte 50 of packet 3 with CE=1 -> next clock CEO=0, Out_byte=0x00, Valid_out=0; relock on next 0xB8 with output 0x47,0x03 for zero payload.
REQ-032 CE spacing 1 clock (back-to-back) and 8 clocks -> identical Out_byte sequence; CEO exactly one clock per accepted byte.

Source files
------------

// File: rtl/dvb_derandomizer.sv
// DVB transport-stream derandomizer. Finds lock on the inverted sync byte
// (0xB8) at the start of each 8-packet group, strips the 1+x^14+x^15
// energy-dispersal scrambling and restores 0x47 on the group-start sync.
module dvb_derandomizer #(
  parameter int MISS_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic [7:0] input_byte,
  input  logic       Valid_in,
  output logic [7:0] Out_byte,
  output logic       CEO,
  output logic       Valid_out,
  output logic       Sop
);

  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [15:1]   SEED     = 15'h00A9;  // bit1..bit15 = 100101010000000
  localparam logic [7:0]    SYNC_INV = 8'hB8;
  localparam logic [7:0]    SYNC     = 8'h47;
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [2:0]    pkt_cnt_q, pkt_cnt_d;
  logic [MW-1:0] miss_q, miss_d, miss_inc;
  logic [15:1]   prbs_q, prbs_d, prbs_nxt;
  logic [7:0]    prbs_byte;
  logic [7:0]    out_byte_q, out_byte_d;
  logic          ceo_q, ceo_d, valid_q, valid_d, sop_q, sop_d;
  logic          accept, trunc, byte_last;

  // Eight generator steps in one clock; first output bit lands in the MSB.
  function automatic logic [22:0] prbs_adv(input logic [15:1] r);
    logic [15:1] s;
    logic [7:0]  b;
    logic        o;
    s = r;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      o = s[14] ^ s[15];
      s = {s[14:1], o};
      b = {b[6:0], o};
    end
    return {s, b};
  endfunction

  // Next PRBS state and the keystream byte for the current position.
  always_comb begin
    {prbs_nxt, prbs_byte} = prbs_adv(prbs_q);
  end

  // Lock FSM, counters and next output values.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    miss_d     = miss_q;
    prbs_d     = prbs_q;
    out_byte_d = out_byte_q;
    valid_d    = valid_q;
    sop_d      = sop_q;
    ceo_d      = 1'b0;
    accept     = CE & Valid_in;
    trunc      = CE & ~Valid_in & (byte_cnt_q != 8'd0);
    byte_last  = (byte_cnt_q == 8'd187);
    miss_inc   = miss_q + MW'(1);

    if (trunc) begin
      // Block ended mid-packet: alignment is no longer trustworthy.
      state_d    = HUNT;
      byte_cnt_d = '0;
      pkt_cnt_d  = '0;
      miss_d     = '0;
      prbs_d     = SEED;
      out_byte_d = input_byte;
      ceo_d      = 1'b1;
      valid_d    = 1'b0;
      sop_d      = 1'b0;
    end else if (accept) begin
      ceo_d = 1'b1;
      if (state_q == HUNT) begin
        if (input_byte == SYNC_INV) begin
          state_d    = LOCKED;
          byte_cnt_d = 8'd1;
          pkt_cnt_d  = '0;
          miss_d     = '0;
          prbs_d     = SEED;
          out_byte_d = SYNC;
          valid_d    = 1'b1;
          sop_d      = 1'b1;
        end else begin
          byte_cnt_d = '0;
          out_byte_d = input_byte;
          valid_d    = 1'b0;
          sop_d      = 1'b0;
        end
      end else begin
        byte_cnt_d = byte_last ? 8'd0 : byte_cnt_q + 8'd1;
        pkt_cnt_d  = byte_last ? pkt_cnt_q + 3'd1 : pkt_cnt_q;
        valid_d    = 1'b1;
        sop_d      = (byte_cnt_q == 8'd0);
        if (byte_cnt_q == 8'd0 && pkt_cnt_q == 3'd0) begin
          // Group start: keystream restarts here without consuming a byte.
          prbs_d = SEED;
          if (input_byte == SYNC_INV) begin
            out_byte_d = SYNC;
            miss_d     = '0;
          end else if (miss_inc == MISS_MAX) begin
            state_d    = HUNT;
            byte_cnt_d = '0;
            pkt_cnt_d  = '0;
            miss_d     = '0;
            out_byte_d = input_byte;
            valid_d    = 1'b0;
            sop_d      = 1'b0;
          end else begin
            out_byte_d = input_byte;
            miss_d     = miss_inc;
          end
        end else if (byte_cnt_q == 8'd0) begin
          // Plain sync bytes are not scrambled but still clock the generator.
          out_byte_d = input_byte;
          prbs_d     = prbs_nxt;
        end else begin
          out_byte_d = input_byte ^ prbs_byte;
          prbs_d     = prbs_nxt;
        end
      end
    end
  end

  // State and registered outputs; reset wins over a coincident strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      byte_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      miss_q     <= '0;
      prbs_q     <= SEED;
      out_byte_q <= '0;
      ceo_q      <= 1'b0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      miss_q     <= miss_d;
      prbs_q     <= prbs_d;
      out_byte_q <= out_byte_d;
      ceo_q      <= ceo_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
    end
  end

  assign Out_byte  = out_byte_q;
  assign CEO       = ceo_q;
  assign Valid_out = valid_q;
  assign Sop       = sop_q;

endmodule

// File: tb/tb_dvb_derandomizer.sv
// Bench for dvb_derandomizer: group-position reference model driven by a
// precomputed 1503-byte keystream, plus literal scenario checks.
module tb_dvb_derandomizer;
  localparam int MISS_LIMIT = 3;
  localparam int GROUP = 1504;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CE = 1'b0;
  logic       Valid_in = 1'b0;
  logic [7:0] input_byte = 8'h00;
  logic [7:0] Out_byte;
  logic       CEO, Valid_out, Sop;

  dvb_derandomizer #(.MISS_LIMIT(MISS_LIMIT)) dut (
    .clk(clk), .reset(reset), .CE(CE), .input_byte(input_byte),
    .Valid_in(Valid_in), .Out_byte(Out_byte), .CEO(CEO),
    .Valid_out(Valid_out), .Sop(Sop)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;

  // keystream byte k is used at group position k+1
  logic [7:0] seq [0:1502];

  // model state: lock flag, position within the 8-packet group, misses
  bit         mlock;
  int         mpos, mmiss;
  logic [7:0] exp_out;
  logic       exp_ceo, exp_valid, exp_sop;

  task automatic build_seq();
    logic [15:1] r;
    logic [7:0]  b;
    logic        o;
    r = 15'h00A9;
    for (int k = 0; k < 1503; k++) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        o = r[14] ^ r[15];
        r = {r[14:1], o};
        b = {b[6:0], o};
      end
      seq[k] = b;
    end
  endtask

  task automatic model_step();
    exp_ceo = 1'b0;
    if (reset) begin
      mlock = 0; mpos = 0; mmiss = 0;
      exp_out = 8'h00; exp_valid = 1'b0; exp_sop = 1'b0;
    end else if (CE && !Valid_in) begin
      if (mlock && (mpos % 188) != 0) begin
        exp_ceo = 1'b1; exp_valid = 1'b0; exp_sop = 1'b0;
        mlock = 0; mpos = 0; mmiss = 0;
      end
    end else if (CE) begin
      exp_ceo = 1'b1;
      if (!mlock) begin
        if (input_byte == 8'hB8) begin
          exp_out = 8'h47; exp_valid = 1'b1; exp_sop = 1'b1;
          mlock = 1; mpos = 1; mmiss = 0;
        end else begin
          exp_valid = 1'b0; exp_sop = 1'b0;
        end
      end else if (mpos == 0) begin
        if (input_byte == 8'hB8) begin
          exp_out = 8'h47; exp_valid = 1'b1; exp_sop = 1'b1; mmiss = 0;
        end else begin
          mmiss++;
          if (mmiss == MISS_LIMIT) begin
            exp_valid = 1'b0; exp_sop = 1'b0; mlock = 0; mmiss = 0;
          end else begin
            exp_out = input_byte; exp_valid = 1'b1; exp_sop = 1'b1;
          end
        end
        if (mlock) mpos = 1;
      end else begin
        exp_valid = 1'b1;
        exp_sop   = ((mpos % 188) == 0);
        exp_out   = exp_sop ? input_byte : (input_byte ^ seq[mpos-1]);
        mpos      = (mpos + 1) % GROUP;
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare();
    chk("ceo", {7'd0, CEO}, {7'd0, exp_ceo});
    chk("valid", {7'd0, Valid_out}, {7'd0, exp_valid});
    if (exp_valid) begin
      chk("out_byte", Out_byte, exp_out);
      chk("sop", {7'd0, Sop}, {7'd0, exp_sop});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [7:0] b, input logic vin);
    CE = 1'b1; Valid_in = vin; input_byte = b;
    tick();
    CE = 1'b0; Valid_in = 1'($urandom); input_byte = 8'($urandom);
  endtask

  // Scrambled all-zero-payload stream byte for a group position.
  function automatic logic [7:0] zbyte(input int p);
    if (p % 188 == 0) return (p == 0) ? 8'hB8 : 8'h47;
    return seq[p-1];
  endfunction

  task automatic do_reset();
    reset = 1'b1; CE = 1'b1; Valid_in = 1'b1; input_byte = 8'hB8;
    tick(); tick();
    reset = 1'b0; CE = 1'b0;
    chk("rst_out", Out_byte, 8'h00);
    chk("rst_ceo", {7'd0, CEO}, 8'h00);
    chk("rst_valid", {7'd0, Valid_out}, 8'h00);
    chk("rst_sop", {7'd0, Sop}, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    logic v;
    build_seq();
    mlock = 0; mpos = 0; mmiss = 0;
    exp_out = 0; exp_ceo = 0; exp_valid = 0; exp_sop = 0;
    chk("seq0", seq[0], 8'h03);
    do_reset();

    // hunt bytes, lock on 0xB8, first keystream byte
    drive(8'h47, 1'b1); chk("hunt0_valid", {7'd0, Valid_out}, 8'h00); chk("hunt0_ceo", {7'd0, CEO}, 8'h01);
    drive(8'h12, 1'b1); chk("hunt1_valid", {7'd0, Valid_out}, 8'h00);
    drive(8'hB8, 1'b1); chk("lock_out", Out_byte, 8'h47); chk("lock_sop", {7'd0, Sop}, 8'h01);
    chk("lock_valid", {7'd0, Valid_out}, 8'h01);
    drive(8'h00, 1'b1); chk("first_prbs", Out_byte, 8'h03); chk("first_sop", {7'd0, Sop}, 8'h00);
    for (int p = 2; p < GROUP; p++) begin drive(zbyte(p), 1'b1); idle($urandom_range(0, 1)); end

    // full zero-payload groups, back-to-back and with 8-clock spacing
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < GROUP; p++) begin
        drive(zbyte(p), 1'b1);
        chk("grp_out", Out_byte, (p % 188 == 0) ? 8'h47 : 8'h00);
        chk("grp_sop", {7'd0, Sop}, (p % 188 == 0) ? 8'h01 : 8'h00);
        if (g == 1) begin idle(7); chk("grp_ceo_hold", {7'd0, CEO}, 8'h00); end
      end

    // three bad group-start bytes force hunt
    for (int g = 0; g < 3; g++)
      for (int p = 0; p < ((g == 2) ? 1 : GROUP); p++) begin
        drive((p == 0) ? 8'h47 : zbyte(p), 1'b1);
        if (p == 0) chk("miss_valid", {7'd0, Valid_out}, (g < 2) ? 8'h01 : 8'h00);
        if (p == 0 && g < 2) chk("miss_out", Out_byte, 8'h47);
      end
    drive(8'h03, 1'b1); chk("after_miss_valid", {7'd0, Valid_out}, 8'h00);
    drive(8'hB8, 1'b1); chk("relock_out", Out_byte, 8'h47);
    drive(8'h00, 1'b1); chk("relock_prbs", Out_byte, 8'h03);

    // truncated block at byte 100 unlocks; at byte 0 it is ignored
    for (int p = 2; p < 100; p++) drive(zbyte(p), 1'b1);
    drive(8'h55, 1'b0); chk("trunc_ceo", {7'd0, CEO}, 8'h01); chk("trunc_valid", {7'd0, Valid_out}, 8'h00);
    drive(8'hB8, 1'b1); chk("trunc_relock", Out_byte, 8'h47);
    for (int p = 1; p < 188; p++) drive(zbyte(p), 1'b1);
    drive(8'h47, 1'b0); chk("ign_ceo", {7'd0, CEO}, 8'h00); chk("ign_valid", {7'd0, Valid_out}, 8'h01);
    for (int p = 188; p < GROUP; p++) drive(zbyte(p), 1'b1);
    drive(8'hB8, 1'b1); chk("ign_next_sync", Out_byte, 8'h47); chk("ign_next_valid", {7'd0, Valid_out}, 8'h01);

    // reset at packet 3 byte 50 with a coincident strobe
    for (int p = 1; p < 3 * 188 + 50; p++) drive(zbyte(p), 1'b1);
    reset = 1'b1; CE = 1'b1; Valid_in = 1'b1; input_byte = zbyte(3 * 188 + 50);
    tick();
    reset = 1'b0; CE = 1'b0;
    chk("mrst_ceo", {7'd0, CEO}, 8'h00); chk("mrst_out", Out_byte, 8'h00);
    chk("mrst_valid", {7'd0, Valid_out}, 8'h00);
    drive(zbyte(3 * 188 + 51), 1'b1);
    drive(8'hB8, 1'b1); chk("mrst_relock", Out_byte, 8'h47);
    drive(8'h00, 1'b1); chk("mrst_prbs", Out_byte, 8'h03);

    // random traffic: mostly-correct syncs, random payload, rare truncation
    for (int i = 0; i < 3000; i++) begin
      if (mpos % 188 == 0 && $urandom_range(0, 9) != 0) b = (mpos == 0) ? 8'hB8 : 8'h47;
      else b = 8'($urandom);
      v = ($urandom_range(0, 49) != 0);
      drive(b, v);
      idle($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
